float_wb_arbiter: RTL and testbench

- Write-side producer for the float register file. It drives fwb_en, fwb_addr and fwb_data.
- It merges two sources: FLW load results, which have priority and no backpressure, and multi-cycle FPU results, which are buffered in a small FIFO.
- It keeps a pending-write scoreboard that decode uses for RAW hazard checks on frs1/frs2.
- It sits between the MEM/FPU completion paths and the float register file, and honours busStall[1] exactly as the register file does.

---
 rtl/float_wb_pkg.sv | 18 +
 rtl/float_wb_fifo.sv | 60 ++++++
 rtl/float_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_float_wb_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_wb_pkg.sv
// rtl/float_wb_pkg.sv - shared widths, FIFO entry type and rd-valid helper for float writeback
package float_wb_pkg;

   localparam int FREG_ADDR_W    = 6;
   localparam int FREG_DATA_W    = 32;
   localparam int FREG_VALID_BIT = 5;

   typedef struct packed {
      logic [FREG_ADDR_W-1:0] addr;
      logic [FREG_DATA_W-1:0] data;
   } fwb_entry_t;

   // A destination names a float register only when the flag is set and the index is non-zero
   function automatic logic freg_valid(input logic [FREG_ADDR_W-1:0] addr);
      return addr[FREG_VALID_BIT] && (addr[FREG_VALID_BIT-1:0] != '0);
   endfunction

endpackage

// File: rtl/float_wb_fifo.sv
// rtl/float_wb_fifo.sv - small circular FIFO buffering FPU results ahead of the writeback stage
module float_wb_fifo
   import float_wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  fwb_entry_t       push_entry,
   input  logic             pop,
   output fwb_entry_t       pop_entry,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   fwb_entry_t       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             push_ok;
   logic             pop_ok;

   // Requests against a full/empty FIFO are ignored so the pointers can never overrun
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;
   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign pop_entry = mem[rd_ptr];

   // Storage array; contents need no reset because count gates every read
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Pointers wrap naturally since the depth is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/float_wb_arbiter.sv
// rtl/float_wb_arbiter.sv - float regfile write port arbiter (loads over FPU FIFO) with pending-write scoreboard; option FWB_EARLY_CLEAR_EN
module float_wb_arbiter
   import float_wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = FREG_ADDR_W,
   parameter int DATA_W     = FREG_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        busStall,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_rd,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              fpu_valid,
   input  logic [ADDR_W-1:0] fpu_rd,
   input  logic [DATA_W-1:0] fpu_data,
   output logic              fpu_ready,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic [ADDR_W-1:0] frs1_addr,
   input  logic [ADDR_W-1:0] frs2_addr,
   output logic              frs1_busy,
   output logic              frs2_busy,
   output logic              fwb_en,
   output logic [ADDR_W-1:0] fwb_addr,
   output logic [DATA_W-1:0] fwb_data
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             stall;
   logic             stall_bit0_unused;
   logic             retire;
   logic             ld_ok;
   logic             fpu_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   fwb_entry_t       push_entry;
   fwb_entry_t       head_entry;
   logic [31:0]      pending;
   logic [31:0]      pending_nxt;

   assign stall             = busStall[1];
   assign stall_bit0_unused = busStall[0];
   assign ld_ok             = ld_valid && freg_valid(ld_rd);
   assign fpu_ready         = (fifo_count < CNT_W'(FIFO_DEPTH));
   assign fpu_push          = fpu_valid && !fifo_full && freg_valid(fpu_rd);
   assign fifo_pop          = !stall && !ld_ok && !fifo_empty;
   assign retire            = fwb_en && !stall;
   assign push_entry        = '{addr: fpu_rd, data: fpu_data};

   float_wb_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (fpu_push),
      .push_entry (push_entry),
      .pop        (fifo_pop),
      .pop_entry  (head_entry),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   // Output stage: frozen under stall, otherwise load beats FIFO head, else drop enable and hold data
   always_ff @(posedge clk) begin
      if (rst) begin
         fwb_en   <= 1'b0;
         fwb_addr <= '0;
         fwb_data <= '0;
      end else if (!stall) begin
         if (ld_ok) begin
            fwb_en   <= 1'b1;
            fwb_addr <= ld_rd;
            fwb_data <= ld_data;
         end else if (!fifo_empty) begin
            fwb_en   <= 1'b1;
            fwb_addr <= head_entry.addr;
            fwb_data <= head_entry.data;
         end else begin
            fwb_en   <= 1'b0;
         end
      end
   end

   // Scoreboard next state: retire clears first so a same-index issue in the same cycle wins
   always_comb begin
      pending_nxt = pending;
      if (retire) begin
         pending_nxt[fwb_addr[4:0]] = 1'b0;
      end
      if (issue_valid && freg_valid(issue_rd)) begin
         pending_nxt[issue_rd[4:0]] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

   // Hazard queries; the early-clear build lets decode see a retiring write as already done
   always_comb begin
      frs1_busy = freg_valid(frs1_addr) && pending[frs1_addr[4:0]];
      frs2_busy = freg_valid(frs2_addr) && pending[frs2_addr[4:0]];
`ifdef FWB_EARLY_CLEAR_EN
      if (retire && (frs1_addr[4:0] == fwb_addr[4:0])) frs1_busy = 1'b0;
      if (retire && (frs2_addr[4:0] == fwb_addr[4:0])) frs2_busy = 1'b0;
`else
      frs1_busy = frs1_busy && 1'b1;
      frs2_busy = frs2_busy && 1'b1;
`endif
   end

endmodule

// File: tb/tb_float_wb_arbiter.sv
// tb/tb_float_wb_arbiter.sv - directed and randomized checks of float_wb_arbiter against a queue-based model
module tb_float_wb_arbiter;

   localparam int DEPTH = 4;
`ifdef FWB_EARLY_CLEAR_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  busStall;
   logic        ld_valid;
   logic [5:0]  ld_rd;
   logic [31:0] ld_data;
   logic        fpu_valid;
   logic [5:0]  fpu_rd;
   logic [31:0] fpu_data;
   logic        fpu_ready;
   logic        issue_valid;
   logic [5:0]  issue_rd;
   logic [5:0]  frs1_addr;
   logic [5:0]  frs2_addr;
   logic        frs1_busy;
   logic        frs2_busy;
   logic        fwb_en;
   logic [5:0]  fwb_addr;
   logic [31:0] fwb_data;

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO as a queue, output stage as three variables, scoreboard as a bit vector
   logic [37:0] m_q [$];
   logic        m_en;
   logic [5:0]  m_addr;
   logic [31:0] m_data;
   logic [31:0] m_pend;

   always #5 clk = ~clk;

   float_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .busStall    (busStall),
      .ld_valid    (ld_valid),
      .ld_rd       (ld_rd),
      .ld_data     (ld_data),
      .fpu_valid   (fpu_valid),
      .fpu_rd      (fpu_rd),
      .fpu_data    (fpu_data),
      .fpu_ready   (fpu_ready),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .frs1_addr   (frs1_addr),
      .frs2_addr   (frs2_addr),
      .frs1_busy   (frs1_busy),
      .frs2_busy   (frs2_busy),
      .fwb_en      (fwb_en),
      .fwb_addr    (fwb_addr),
      .fwb_data    (fwb_data)
   );

   // Loads are never presented while writeback is frozen
   always @(negedge clk) begin
      assert (rst || !(ld_valid && busStall[1])) else $error("ld_valid asserted during busStall[1]");
   end

   function automatic bit ok_rd(input logic [5:0] a);
      return a[5] && (a[4:0] != 5'd0);
   endfunction

   function automatic logic m_busy(input logic [5:0] a);
      logic b;
      b = ok_rd(a) && m_pend[a[4:0]];
      if (EARLY && m_en && !busStall[1] && (a[4:0] == m_addr[4:0])) b = 1'b0;
      return b;
   endfunction

   function automatic logic [5:0] rand_rd();
      logic [5:0] r;
      r[4:0] = 5'($urandom_range(0, 7));
      r[5]   = ($urandom_range(0, 7) != 0);
      return r;
   endfunction

   task automatic model_update();
      logic [37:0] e;
      bit          accept;
      if (rst) begin
         m_q.delete();
         m_en = 1'b0; m_addr = '0; m_data = '0; m_pend = '0;
         return;
      end
      accept = fpu_valid && ok_rd(fpu_rd) && (m_q.size() < DEPTH);
      if (m_en && !busStall[1]) m_pend[m_addr[4:0]] = 1'b0;
      if (issue_valid && ok_rd(issue_rd)) m_pend[issue_rd[4:0]] = 1'b1;
      if (!busStall[1]) begin
         if (ld_valid && ok_rd(ld_rd)) begin
            m_en = 1'b1; m_addr = ld_rd; m_data = ld_data;
         end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_en = 1'b1; m_addr = e[37:32]; m_data = e[31:0];
         end else begin
            m_en = 1'b0;
         end
      end
      if (accept) m_q.push_back({fpu_rd, fpu_data});
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      busStall = 2'b00; ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
      fpu_valid = 1'b0; fpu_rd = '0; fpu_data = '0;
      issue_valid = 1'b0; issue_rd = '0; frs1_addr = '0; frs2_addr = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle_inputs();
      tick(); tick();
      rst = 1'b0; frs1_addr = 6'h25; #1;
      checks++; if (fwb_en !== 1'b0) begin errors++; $display("FAIL reset_fwb_en: got %0b expected 0", fwb_en); end
      checks++; if (fwb_addr !== 6'h00) begin errors++; $display("FAIL reset_fwb_addr: got %0h expected 0", fwb_addr); end
      checks++; if (fwb_data !== 32'h0) begin errors++; $display("FAIL reset_fwb_data: got %0h expected 0", fwb_data); end
      checks++; if (fpu_ready !== 1'b1) begin errors++; $display("FAIL reset_fpu_ready: got %0b expected 1", fpu_ready); end
      checks++; if (frs1_busy !== 1'b0) begin errors++; $display("FAIL reset_frs1_busy: got %0b expected 0", frs1_busy); end
      tick();
   endtask

   task automatic test_load_hazard();
      issue_valid = 1'b1; issue_rd = 6'h23; frs1_addr = 6'h23;
      tick();
      issue_valid = 1'b0; #1;
      checks++; if (frs1_busy !== 1'b1) begin errors++; $display("FAIL hazard_busy_after_issue: got %0b expected 1", frs1_busy); end
      tick();
      ld_valid = 1'b1; ld_rd = 6'h23; ld_data = 32'h3F80_0000; #1;
      checks++; if (frs1_busy !== 1'b1) begin errors++; $display("FAIL hazard_busy_at_load: got %0b expected 1", frs1_busy); end
      tick();
      ld_valid = 1'b0; #1;
      checks++; if (fwb_en !== 1'b1) begin errors++; $display("FAIL load_fwb_en: got %0b expected 1", fwb_en); end
      checks++; if (fwb_addr !== 6'h23) begin errors++; $display("FAIL load_fwb_addr: got %0h expected 23", fwb_addr); end
      checks++; if (fwb_data !== 32'h3F80_0000) begin errors++; $display("FAIL load_fwb_data: got %0h expected 3f800000", fwb_data); end
      checks++; if (frs1_busy !== !EARLY) begin errors++; $display("FAIL hazard_busy_at_retire: got %0b expected %0b", frs1_busy, !EARLY); end
      tick();
      checks++; if (frs1_busy !== 1'b0) begin errors++; $display("FAIL hazard_busy_after_retire: got %0b expected 0", frs1_busy); end
      checks++; if (fwb_en !== 1'b0) begin errors++; $display("FAIL load_idle_en: got %0b expected 0", fwb_en); end
      checks++; if (fwb_addr !== 6'h23) begin errors++; $display("FAIL load_idle_addr_hold: got %0h expected 23", fwb_addr); end
   endtask

   task automatic test_fifo_fill();
      int got;
      logic [5:0]  exp_a;
      logic [31:0] exp_d;
      busStall = 2'b10;
      for (int k = 0; k < 4; k++) begin
         fpu_valid = 1'b1; fpu_rd = 6'h21 + 6'(k); fpu_data = 32'hC000_0000 + 32'(k);
         tick();
      end
      fpu_valid = 1'b1; fpu_rd = 6'h25; fpu_data = 32'hC000_0004; #1;
      checks++; if (fpu_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready: got %0b expected 0", fpu_ready); end
      checks++; if (fwb_en !== 1'b0) begin errors++; $display("FAIL fifo_stalled_en: got %0b expected 0", fwb_en); end
      tick();
      checks++; if (fpu_ready !== 1'b0) begin errors++; $display("FAIL fifo_held_ready: got %0b expected 0", fpu_ready); end
      busStall = 2'b00;
      tick();
      checks++; if (fpu_ready !== 1'b1) begin errors++; $display("FAIL fifo_ready_after_pop: got %0b expected 1", fpu_ready); end
      checks++; if (fwb_en !== 1'b1 || fwb_addr !== 6'h21) begin errors++; $display("FAIL fifo_first_wb: got en=%0b addr=%0h expected en=1 addr=21", fwb_en, fwb_addr); end
      got = 1;
      for (int c = 0; c < 10 && got < 5; c++) begin
         tick();
         fpu_valid = 1'b0;
         if (fwb_en) begin
            exp_a = 6'h21 + 6'(got);
            exp_d = 32'hC000_0000 + 32'(got);
            checks++; if (fwb_addr !== exp_a || fwb_data !== exp_d) begin errors++; $display("FAIL fifo_order: got %0h/%0h expected %0h/%0h", fwb_addr, fwb_data, exp_a, exp_d); end
            got++;
         end
      end
      checks++; if (got != 5) begin errors++; $display("FAIL fifo_drain_count: got %0d writebacks expected 5", got); end
      fpu_valid = 1'b0;
      tick();
   endtask

   task automatic test_load_priority();
      fpu_valid = 1'b1; fpu_rd = 6'h26; fpu_data = 32'h4040_0000;
      tick();
      fpu_valid = 1'b0; ld_valid = 1'b1; ld_rd = 6'h27; ld_data = 32'h4080_0000;
      tick();
      ld_valid = 1'b0;
      checks++; if (fwb_en !== 1'b1 || fwb_addr !== 6'h27 || fwb_data !== 32'h4080_0000) begin errors++; $display("FAIL prio_load_first: got en=%0b %0h/%0h expected en=1 27/40800000", fwb_en, fwb_addr, fwb_data); end
      tick();
      checks++; if (fwb_en !== 1'b1 || fwb_addr !== 6'h26 || fwb_data !== 32'h4040_0000) begin errors++; $display("FAIL prio_fifo_next: got en=%0b %0h/%0h expected en=1 26/40400000", fwb_en, fwb_addr, fwb_data); end
      tick();
      checks++; if (fwb_en !== 1'b0) begin errors++; $display("FAIL prio_idle: got %0b expected 0", fwb_en); end
   endtask

   task automatic test_stall();
      issue_valid = 1'b1; issue_rd = 6'h28; frs1_addr = 6'h28;
      tick();
      issue_valid = 1'b0;
      ld_valid = 1'b1; ld_rd = 6'h28; ld_data = 32'h4100_0000;
      fpu_valid = 1'b1; fpu_rd = 6'h29; fpu_data = 32'h4110_0000;
      tick();
      ld_valid = 1'b0; fpu_valid = 1'b0; busStall = 2'b10;
      for (int s = 0; s < 3; s++) begin
         #1;
         checks++; if (fwb_en !== 1'b1 || fwb_addr !== 6'h28 || fwb_data !== 32'h4100_0000) begin errors++; $display("FAIL stall_hold[%0d]: got en=%0b %0h/%0h expected en=1 28/41000000", s, fwb_en, fwb_addr, fwb_data); end
         checks++; if (frs1_busy !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d]: got %0b expected 1", s, frs1_busy); end
         tick();
      end
      busStall = 2'b00; #1;
      checks++; if (fwb_addr !== 6'h28) begin errors++; $display("FAIL stall_release_addr: got %0h expected 28", fwb_addr); end
      checks++; if (frs1_busy !== !EARLY) begin errors++; $display("FAIL stall_release_busy: got %0b expected %0b", frs1_busy, !EARLY); end
      tick();
      checks++; if (fwb_en !== 1'b1 || fwb_addr !== 6'h29 || fwb_data !== 32'h4110_0000) begin errors++; $display("FAIL stall_no_pop: got en=%0b %0h/%0h expected en=1 29/41100000", fwb_en, fwb_addr, fwb_data); end
      checks++; if (frs1_busy !== 1'b0) begin errors++; $display("FAIL stall_busy_cleared: got %0b expected 0", frs1_busy); end
      tick();
   endtask

   task automatic test_drop();
      fpu_valid = 1'b1; fpu_rd = 6'h20; fpu_data = 32'hDEAD_0001;
      ld_valid = 1'b1; ld_rd = 6'h05; ld_data = 32'hDEAD_0002;
      issue_valid = 1'b1; issue_rd = 6'h20;
      tick();
      idle_inputs();
      checks++; if (fwb_en !== 1'b0) begin errors++; $display("FAIL drop_no_load: got %0b expected 0", fwb_en); end
      tick();
      checks++; if (fwb_en !== 1'b0) begin errors++; $display("FAIL drop_no_push: got %0b expected 0", fwb_en); end
      checks++; if (fpu_ready !== 1'b1) begin errors++; $display("FAIL drop_ready: got %0b expected 1", fpu_ready); end
   endtask

   task automatic test_set_clear();
      issue_valid = 1'b1; issue_rd = 6'h2A; frs1_addr = 6'h2A; frs2_addr = 6'h2A;
      tick();
      issue_valid = 1'b0; ld_valid = 1'b1; ld_rd = 6'h2A; ld_data = 32'h4120_0000;
      tick();
      ld_valid = 1'b0; issue_valid = 1'b1; issue_rd = 6'h2A; #1;
      checks++; if (frs2_busy !== !EARLY) begin errors++; $display("FAIL setclr_during: got %0b expected %0b", frs2_busy, !EARLY); end
      tick();
      issue_valid = 1'b0; #1;
      checks++; if (frs2_busy !== 1'b1) begin errors++; $display("FAIL setclr_set_wins: got %0b expected 1", frs2_busy); end
      tick();
      checks++; if (frs1_busy !== 1'b1) begin errors++; $display("FAIL setclr_stays: got %0b expected 1", frs1_busy); end
      ld_valid = 1'b1; ld_rd = 6'h2A; ld_data = 32'h4130_0000;
      tick();
      ld_valid = 1'b0;
      tick();
      checks++; if (frs1_busy !== 1'b0) begin errors++; $display("FAIL setclr_final_clear: got %0b expected 0", frs1_busy); end
   endtask

   task automatic test_random();
      bit   hold;
      logic exp_rdy;
      hold = 1'b0;
      for (int i = 0; i < 400; i++) begin
         rst = (i == 250);
         busStall[1] = ($urandom_range(0, 3) == 0);
         busStall[0] = 1'($urandom_range(0, 1));
         ld_valid = !busStall[1] && ($urandom_range(0, 2) == 0);
         ld_rd = rand_rd(); ld_data = $urandom;
         if (!hold) begin
            fpu_valid = 1'($urandom_range(0, 1)); fpu_rd = rand_rd(); fpu_data = $urandom;
         end
         issue_valid = 1'($urandom_range(0, 1)); issue_rd = rand_rd();
         frs1_addr = rand_rd(); frs2_addr = rand_rd();
         #1;
         exp_rdy = (m_q.size() < DEPTH);
         checks++; if (fwb_en !== m_en) begin errors++; $display("FAIL rand_en @%0d: got %0b expected %0b", i, fwb_en, m_en); end
         checks++; if (fwb_addr !== m_addr) begin errors++; $display("FAIL rand_addr @%0d: got %0h expected %0h", i, fwb_addr, m_addr); end
         checks++; if (fwb_data !== m_data) begin errors++; $display("FAIL rand_data @%0d: got %0h expected %0h", i, fwb_data, m_data); end
         checks++; if (fpu_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready @%0d: got %0b expected %0b", i, fpu_ready, exp_rdy); end
         checks++; if (frs1_busy !== m_busy(frs1_addr)) begin errors++; $display("FAIL rand_busy1 @%0d: got %0b expected %0b", i, frs1_busy, m_busy(frs1_addr)); end
         checks++; if (frs2_busy !== m_busy(frs2_addr)) begin errors++; $display("FAIL rand_busy2 @%0d: got %0b expected %0b", i, frs2_busy, m_busy(frs2_addr)); end
         hold = !rst && fpu_valid && ok_rd(fpu_rd) && !exp_rdy;
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      m_en = 1'b0; m_addr = '0; m_data = '0; m_pend = '0;
      test_reset();
      test_load_hazard();
      test_fifo_fill();
      test_load_priority();
      test_stall();
      test_drop();
      test_set_clear();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
